gpio_pattern_seq: RTL
=====================

Name: gpio_pattern_seq

Overview:
- AHB-Lite slave that sequences the GPIO output datapath by playing a programmed table of GPIO output words onto the pins, each word held for a programmable number of HCLK cycles.
- Sits between the CPU-owned GPIO register bridge outputs (CPU_DIR/CPU_WDATA) and the pad logic.
- Idle: the CPU-driven values pass straight through to the pads.
- Running: the sequencer owns the pins.

Parameters:
- GPIO_WIDTH, 16, pin count; range 1..16.
- DEPTH, 16, pattern table entries; power of 2, 2..32.
- HOLD_W, 16, width of the per-entry hold counter.

Ports:
- HCLK  in  1  system clock
- HRESETn  in  1  asynchronous active-low reset
- HSEL  in  1  slave select
- HADDR  in  32  address; bits [7:2] decoded
- HTRANS  in  2  transfer type; HTRANS[1] marks an active transfer
- HSIZE  in  3  ignored; all accesses treated as 32-bit
- HPROT  in  4  ignored
- HWRITE  in  1  write strobe
- HWDATA  in  32  write data
- HREADY  in  1  bus ready
- HREADYOUT  out  1  tied to 1
- HRDATA  out  32  read data
- HRESP  out  2  tied to 0
- CPU_DIR  in  GPIO_WIDTH  direction from the CPU GPIO bridge
- CPU_WDATA  in  GPIO_WIDTH  output data from the CPU GPIO bridge
- GPIO_DIR  out  GPIO_WIDTH  direction to pads
- GPIO_WDATA  out  GPIO_WIDTH  output data to pads
- SEQ_BUSY  out  1  sequencer owns the pins

Behaviour:
- Bus timing:
  - Zero-wait-state.
  - Address phase qualified by HSEL & HTRANS[1] & HREADY; HADDR[7:2] is registered.
  - Write data is committed at the clock edge that ends the data phase.
  - HRDATA is combinational from the registered address; unused bits read 0.
- Register map (offsets):
  - 0x00 CTRL, write-only, reads 0.
    - bit0 START: write 1 to start.
    - bit1 STOP: write 1 to stop.
  - 0x04 STATUS.
    - bit0 BUSY (RO).
    - bit1 DONE (sticky; write 1 to clear).
    - bit2 LOOP (RW): restart from entry 0 after the last entry.
  - 0x08 LEN: RW, $clog2(DEPTH)+1 bits, number of entries to play.
  - 0x0C HOLD: RW, HOLD_W bits; each entry is driven for HOLD+1 cycles.
  - 0x10 SEQ_DIR: RW, GPIO_WIDTH bits; GPIO_DIR while running.
  - 0x40 + 4*i, i < DEPTH: TABLE[i], RW, GPIO_WIDTH bits.
- Reset values:
  - All registers and TABLE are 0; state IDLE; SEQ_BUSY=0.
  - GPIO_DIR=CPU_DIR and GPIO_WDATA=CPU_WDATA (passthrough).
- FSM states: IDLE, PLAY.
  - IDLE -> PLAY: on a START commit with 1 <= LEN <= DEPTH. At that edge, idx=0, cnt=HOLD, BUSY=1.
  - PLAY outputs: GPIO_DIR=SEQ_DIR and GPIO_WDATA=TABLE[idx], starting the cycle after the START edge.
  - PLAY counting: while cnt != 0, cnt decrements each cycle.
  - PLAY advance: when cnt==0 and idx < LEN-1, idx increments and cnt reloads HOLD.
  - PLAY end of pass: when cnt==0 and idx==LEN-1:
    - LOOP=1: idx=0, cnt=HOLD.
    - LOOP=0: go to IDLE and set DONE.
  - PLAY -> IDLE on a STOP commit, at that edge. DONE is not set. Passthrough resumes the next cycle.
- Boundary conditions:
  - START while PLAY: ignored.
  - START and STOP in the same write: STOP wins; the block is IDLE afterwards.
  - START with LEN=0 or LEN>DEPTH: ignored; DONE unchanged.
  - Writes to LEN, HOLD, SEQ_DIR or TABLE during PLAY: ignored. Reads still return the stored values.
  - HOLD written as 0: each entry lasts exactly 1 cycle.
  - LOOP cleared mid-run: the current pass completes, then the block goes IDLE with DONE set.
  - DONE set and a W1C write in the same cycle: set wins.
  - HRESETn asserted mid-run: immediate IDLE and passthrough; all registers return to reset values.

Optional Feature:
- Macro: GPIO_PATTERN_SEQ_IRQ_EN.
- Defined:
  - Adds output port SEQ_IRQ (1 bit) and STATUS bit3 IRQ_EN (RW, reset 0).
  - SEQ_IRQ = DONE & IRQ_EN, registered: it asserts the cycle after DONE sets.
- Undefined: no port and no STATUS bit3; bit3 reads 0.

Decomposition:
- Package gpio_pattern_seq_pkg holds:
  - Register offsets: CTRL, STATUS, LEN, HOLD, SEQ_DIR, TABLE_BASE.
  - CTRL and STATUS bit indices.
  - State enum {IDLE, PLAY}.
- One sub-module, gpio_seq_table: DEPTH x GPIO_WIDTH flop array with a write port (write enable, index, data) and two combinational read ports (bus read, play index).

Test Plan:
- Pattern run: LEN=3, HOLD=2, TABLE={0x0001,0x0002,0x0004}, SEQ_DIR=0xFFFF, START -> GPIO_WDATA shows 0x0001, 0x0002, 0x0004 for 3 cycles each. Passthrough resumes and DONE=1 at cycle 10 after START.
- Loop then stop: LOOP=1, LEN=2, HOLD=0, then START -> outputs alternate TABLE[0]/TABLE[1] every cycle. STOP -> passthrough next cycle, DONE=0, BUSY=0.
- Illegal start: START with LEN=0, then START with LEN=DEPTH+1 -> BUSY stays 0, GPIO_* equal CPU_*. A START commit during PLAY leaves idx unaffected.
- Write protection: during PLAY, write TABLE[1]=0xBEEF -> the readback and played value keep the old data.
- Reset mid-run: assert HRESETn low during PLAY -> GPIO_DIR=CPU_DIR, STATUS=0, and all TABLE entries read 0 after release.
- IRQ (with GPIO_PATTERN_SEQ_IRQ_EN): IRQ_EN=1, one-entry run -> SEQ_IRQ rises 1 cycle after DONE. W1C of DONE drops SEQ_IRQ the next cycle.

Source files
------------

// File: rtl/gpio_pattern_seq_pkg.sv
// Shared definitions for the GPIO pattern sequencer: register offsets,
// CTRL/STATUS bit positions and the sequencer state encoding.
package gpio_pattern_seq_pkg;

    localparam logic [7:0] OFS_CTRL       = 8'h00;
    localparam logic [7:0] OFS_STATUS     = 8'h04;
    localparam logic [7:0] OFS_LEN        = 8'h08;
    localparam logic [7:0] OFS_HOLD       = 8'h0C;
    localparam logic [7:0] OFS_SEQ_DIR    = 8'h10;
    localparam logic [7:0] OFS_TABLE_BASE = 8'h40;

    localparam int CTRL_START  = 0;
    localparam int CTRL_STOP   = 1;

    localparam int STAT_BUSY   = 0;
    localparam int STAT_DONE   = 1;
    localparam int STAT_LOOP   = 2;
    localparam int STAT_IRQ_EN = 3;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    // The bus decodes word addresses (HADDR[7:2]); convert a byte offset to one.
    function automatic logic [5:0] word_of(input logic [7:0] ofs);
        return ofs[7:2];
    endfunction

endpackage

// File: rtl/gpio_pattern_seq_if.sv
// AHB-Lite signal bundle between the bus fabric (master side) and the
// GPIO pattern sequencer (slave side).
interface gpio_pattern_seq_if;

    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic [1:0]  HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
        input  HREADYOUT, HRDATA, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
        output HREADYOUT, HRDATA, HRESP
    );

endinterface

// File: rtl/gpio_seq_table.sv
// Pattern table storage: DEPTH x GPIO_WIDTH flops, one write port and two
// independent combinational read ports (bus readback and playback).
module gpio_seq_table #(
    parameter int DEPTH      = 16,
    parameter int GPIO_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   widx,
    input  logic [GPIO_WIDTH-1:0]      wdata,
    input  logic [$clog2(DEPTH)-1:0]   ridx_bus,
    output logic [GPIO_WIDTH-1:0]      rdata_bus,
    input  logic [$clog2(DEPTH)-1:0]   ridx_play,
    output logic [GPIO_WIDTH-1:0]      rdata_play
);

    logic [GPIO_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata_bus  = mem[ridx_bus];
    assign rdata_play = mem[ridx_play];

endmodule

// File: rtl/gpio_pattern_seq.sv
// AHB-Lite GPIO pattern sequencer: plays a table of output words onto the pads,
// otherwise passes the CPU GPIO bridge through. GPIO_PATTERN_SEQ_IRQ_EN adds SEQ_IRQ.
//
// state | meaning
// IDLE  | CPU_DIR/CPU_WDATA pass straight through to the pads
// PLAY  | SEQ_DIR and TABLE[idx] drive the pads, each entry for HOLD+1 cycles
module gpio_pattern_seq
    import gpio_pattern_seq_pkg::*;
#(
    parameter int GPIO_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int HOLD_W     = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    gpio_pattern_seq_if.slave     bus,
    input  logic [GPIO_WIDTH-1:0] CPU_DIR,
    input  logic [GPIO_WIDTH-1:0] CPU_WDATA,
    output logic [GPIO_WIDTH-1:0] GPIO_DIR,
    output logic [GPIO_WIDTH-1:0] GPIO_WDATA,
    output logic                  SEQ_BUSY
`ifdef GPIO_PATTERN_SEQ_IRQ_EN
    ,
    output logic                  SEQ_IRQ
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int LEN_W = IDX_W + 1;

    state_t state, next_state;

    logic                  wr_q;
    logic [5:0]            addr_q;
    logic [LEN_W-1:0]      len_q;
    logic [HOLD_W-1:0]     hold_q;
    logic [GPIO_WIDTH-1:0] seq_dir_q;
    logic                  loop_q;
    logic                  done_q;
    logic                  irq_en;
    logic [IDX_W-1:0]      idx_q;
    logic [HOLD_W-1:0]     cnt_q;

    logic                  busy;
    logic                  hit_ctrl, hit_status, hit_len, hit_hold, hit_dir, hit_tbl;
    logic [5:0]            tbl_off;
    logic [IDX_W-1:0]      tbl_idx;
    logic                  wr_ctrl, wr_status, cfg_we;
    logic                  start_cmd, stop_cmd, len_ok, go;
    logic [LEN_W-1:0]      len_m1;
    logic                  pass_end, done_set;
    logic [GPIO_WIDTH-1:0] tbl_rdata_bus, tbl_rdata_play;
    logic [31:0]           rdata;
    logic                  unused_bits;

    // Address phase capture; the write commits at the edge ending the data phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_q   <= 1'b0;
            addr_q <= '0;
        end else begin
            wr_q <= bus.HSEL & bus.HTRANS[1] & bus.HREADY & bus.HWRITE;
            if (bus.HSEL && bus.HTRANS[1] && bus.HREADY) begin
                addr_q <= bus.HADDR[7:2];
            end
        end
    end

    assign hit_ctrl   = (addr_q == word_of(OFS_CTRL));
    assign hit_status = (addr_q == word_of(OFS_STATUS));
    assign hit_len    = (addr_q == word_of(OFS_LEN));
    assign hit_hold   = (addr_q == word_of(OFS_HOLD));
    assign hit_dir    = (addr_q == word_of(OFS_SEQ_DIR));
    assign hit_tbl    = (addr_q >= word_of(OFS_TABLE_BASE)) &&
                        (addr_q <  word_of(OFS_TABLE_BASE) + 6'(DEPTH));
    assign tbl_off    = addr_q - word_of(OFS_TABLE_BASE);
    assign tbl_idx    = tbl_off[IDX_W-1:0];

    assign wr_ctrl    = wr_q & hit_ctrl;
    assign wr_status  = wr_q & hit_status;
    assign cfg_we     = wr_q & ~busy;

    // STOP dominates START when both bits are written together.
    assign stop_cmd   = wr_ctrl & bus.HWDATA[CTRL_STOP];
    assign start_cmd  = wr_ctrl & bus.HWDATA[CTRL_START] & ~bus.HWDATA[CTRL_STOP];
    assign len_ok     = (len_q != '0) && (len_q <= LEN_W'(DEPTH));
    assign go         = (state == IDLE) && start_cmd && len_ok;

    assign len_m1     = len_q - LEN_W'(1);
    assign pass_end   = (state == PLAY) && (cnt_q == '0) && (idx_q == len_m1[IDX_W-1:0]);
    assign done_set   = pass_end && !loop_q && !stop_cmd;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (go) next_state = PLAY;
            PLAY: if (stop_cmd || (pass_end && !loop_q)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state == PLAY);
        GPIO_DIR   = CPU_DIR;
        GPIO_WDATA = CPU_WDATA;
        if (busy) begin
            GPIO_DIR   = seq_dir_q;
            GPIO_WDATA = tbl_rdata_play;
        end
    end

    assign SEQ_BUSY = busy;

    // Hold timer counts down to zero, then the index steps (or wraps at pass end).
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            idx_q <= '0;
            cnt_q <= '0;
        end else if (state == IDLE) begin
            if (go) begin
                idx_q <= '0;
                cnt_q <= hold_q;
            end
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - HOLD_W'(1);
        end else begin
            cnt_q <= hold_q;
            idx_q <= pass_end ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            len_q     <= '0;
            hold_q    <= '0;
            seq_dir_q <= '0;
            loop_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            if (cfg_we && hit_len)  len_q     <= bus.HWDATA[LEN_W-1:0];
            if (cfg_we && hit_hold) hold_q    <= bus.HWDATA[HOLD_W-1:0];
            if (cfg_we && hit_dir)  seq_dir_q <= bus.HWDATA[GPIO_WIDTH-1:0];
            if (wr_status)          loop_q    <= bus.HWDATA[STAT_LOOP];
            if (done_set) begin
                done_q <= 1'b1;
            end else if (wr_status && bus.HWDATA[STAT_DONE]) begin
                done_q <= 1'b0;
            end
        end
    end

`ifdef GPIO_PATTERN_SEQ_IRQ_EN
    logic irq_en_q;
    logic irq_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_status) irq_en_q <= bus.HWDATA[STAT_IRQ_EN];
            irq_q <= done_q & irq_en_q;
        end
    end

    assign irq_en  = irq_en_q;
    assign SEQ_IRQ = irq_q;
`else
    assign irq_en = 1'b0;
`endif

    gpio_seq_table #(
        .DEPTH      (DEPTH),
        .GPIO_WIDTH (GPIO_WIDTH)
    ) u_table (
        .clk        (HCLK),
        .rst_n      (HRESETn),
        .we         (cfg_we & hit_tbl),
        .widx       (tbl_idx),
        .wdata      (bus.HWDATA[GPIO_WIDTH-1:0]),
        .ridx_bus   (tbl_idx),
        .rdata_bus  (tbl_rdata_bus),
        .ridx_play  (idx_q),
        .rdata_play (tbl_rdata_play)
    );

    always_comb begin
        rdata = '0;
        if (hit_status) begin
            rdata[STAT_BUSY]   = busy;
            rdata[STAT_DONE]   = done_q;
            rdata[STAT_LOOP]   = loop_q;
            rdata[STAT_IRQ_EN] = irq_en;
        end else if (hit_len) begin
            rdata[LEN_W-1:0] = len_q;
        end else if (hit_hold) begin
            rdata[HOLD_W-1:0] = hold_q;
        end else if (hit_dir) begin
            rdata[GPIO_WIDTH-1:0] = seq_dir_q;
        end else if (hit_tbl) begin
            rdata[GPIO_WIDTH-1:0] = tbl_rdata_bus;
        end
    end

    assign bus.HRDATA    = rdata;
    assign bus.HREADYOUT = 1'b1;
    assign bus.HRESP     = 2'b00;

    assign unused_bits = ^{bus.HSIZE, bus.HPROT, bus.HADDR[31:8], bus.HADDR[1:0],
                           bus.HTRANS[0], bus.HWDATA, tbl_off, len_m1};

endmodule
